// File: rtl/ir_cam_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : ir_cam_sequencer
// Brief    : Wii IR camera sequencer. Runs the init writes and the
//            pointer-write/13-byte-read poll loop on top of i2c_master, and
//            unpacks extended-mode blob data. Build option:
//            IR_CAM_ALL_BLOBS_EN adds blobs 1..3.
// Revision : 1.0 - initial release
// ============================================================================
module ir_cam_sequencer #(
    parameter logic [6:0]  I2C_ADDR       = 7'h58,
    parameter logic [23:0] STARTUP_CYCLES = 24'd1000,
    parameter logic [23:0] GAP_CYCLES     = 24'd500,
    parameter logic [23:0] POLL_CYCLES    = 24'd10000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       m_ready,
    input  logic       m_data_req,
    input  logic       m_data_ready,
    input  logic [7:0] m_data_out,
    output logic       m_start,
    output logic [6:0] m_addr,
    output logic       m_rw,
    output logic [4:0] m_packets,
    output logic [7:0] m_data,
    output logic [9:0] blob_x,
    output logic [9:0] blob_y,
    output logic       blob_valid,
`ifdef IR_CAM_ALL_BLOBS_EN
    output logic [9:0] blob1_x,
    output logic [9:0] blob1_y,
    output logic       blob1_valid,
    output logic [9:0] blob2_x,
    output logic [9:0] blob2_y,
    output logic       blob2_valid,
    output logic [9:0] blob3_x,
    output logic [9:0] blob3_y,
    output logic       blob3_valid,
`endif
    output logic       frame_stb,
    output logic       init_done
);

`ifdef IR_CAM_ALL_BLOBS_EN
    localparam int c_nblob = 4;
`else
    localparam int c_nblob = 1;
`endif
    localparam int         c_last_byte = 3 * c_nblob;
    localparam logic [3:0] c_read_len  = 4'd13;
    localparam logic [2:0] c_last_init = 3'd5;
    localparam logic [7:0] c_ptr_reg   = 8'h36;

    typedef enum logic [2:0] {
        S_WAIT    = 3'd0,
        S_ISSUE   = 3'd1,
        S_BUSY    = 3'd2,
        S_DONE    = 3'd3,
        S_PUBLISH = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        K_INIT = 2'd0,
        K_PTR  = 2'd1,
        K_READ = 2'd2
    } kind_t;

    function automatic logic [7:0] init_byte(input logic [2:0] k, input logic sel_val);
        logic [15:0] e;
        case (k)
            3'd0:    e = 16'h3001;
            3'd1:    e = 16'h3008;
            3'd2:    e = 16'h0690;
            3'd3:    e = 16'h08C0;
            3'd4:    e = 16'h1A40;
            default: e = 16'h3303;
        endcase
        return sel_val ? e[7:0] : e[15:8];
    endfunction

    function automatic logic [7:0] byte_sel(input kind_t kind, input logic [2:0] k,
                                            input logic [3:0] idx);
        logic [7:0] b;
        b = 8'h00;
        if (kind == K_INIT && idx == 4'd0)      b = init_byte(k, 1'b0);
        else if (kind == K_INIT && idx == 4'd1) b = init_byte(k, 1'b1);
        else if (kind == K_PTR && idx == 4'd0)  b = c_ptr_reg;
        return b;
    endfunction

    state_t      state_q, state_d;
    kind_t       kind_q, kind_d;
    logic [2:0]  init_k_q, init_k_d;
    logic [23:0] timer_q, timer_d;
    logic [3:0]  idx_q, idx_d;
    logic [3:0]  rbyte_q, rbyte_d;
    logic        m_data_req_q, m_data_req_d;
    logic [7:0]  rbuf_q [1:c_last_byte];
    logic [7:0]  rbuf_d [1:c_last_byte];
    logic [9:0]  blob_x_q [c_nblob];
    logic [9:0]  blob_x_d [c_nblob];
    logic [9:0]  blob_y_q [c_nblob];
    logic [9:0]  blob_y_d [c_nblob];
    logic        blob_valid_q [c_nblob];
    logic        blob_valid_d [c_nblob];
    logic        init_done_q, init_done_d;
    logic        frame_stb_q, frame_stb_d;
    logic        m_start_q, m_start_d;
    logic        m_rw_q, m_rw_d;
    logic [4:0]  m_packets_q, m_packets_d;
    logic [7:0]  m_data_q, m_data_d;
    logic        w_req_fall;

    always_comb begin
        state_d      = state_q;
        kind_d       = kind_q;
        init_k_d     = init_k_q;
        timer_d      = timer_q;
        idx_d        = idx_q;
        rbyte_d      = rbyte_q;
        rbuf_d       = rbuf_q;
        blob_x_d     = blob_x_q;
        blob_y_d     = blob_y_q;
        blob_valid_d = blob_valid_q;
        init_done_d  = init_done_q;
        frame_stb_d  = 1'b0;
        m_rw_d       = m_rw_q;
        m_packets_d  = m_packets_q;
        m_data_req_d = m_data_req;
        w_req_fall   = m_data_req_q & ~m_data_req;

        // Read bytes are captured in any state so a pulse coinciding with a
        // state change is never lost.
        if (kind_q == K_READ && m_data_ready && rbyte_q < c_read_len) begin
            for (int i = 1; i <= c_last_byte; i++) begin
                if (rbyte_q == 4'(i)) rbuf_d[i] = m_data_out;
            end
            rbyte_d = rbyte_q + 4'd1;
        end

        case (state_q)
            S_WAIT: begin
                idx_d   = 4'd0;
                rbyte_d = 4'd0;
                if (timer_q == 24'd0) state_d = S_ISSUE;
                else                  timer_d = timer_q - 24'd1;
            end
            S_ISSUE, S_BUSY: begin
                if (w_req_fall && idx_q != 4'hF) idx_d = idx_q + 4'd1;
                if (state_q == S_ISSUE && !m_ready)     state_d = S_BUSY;
                else if (state_q == S_BUSY && m_ready)  state_d = S_DONE;
            end
            S_DONE: begin
                idx_d   = 4'd0;
                state_d = S_WAIT;
                timer_d = GAP_CYCLES;
                case (kind_q)
                    K_INIT: begin
                        if (init_k_q == c_last_init) begin
                            init_done_d = 1'b1;
                            kind_d      = K_PTR;
                        end else begin
                            init_k_d = init_k_q + 3'd1;
                        end
                    end
                    K_PTR: kind_d = K_READ;
                    default: begin
                        timer_d = POLL_CYCLES;
                        if (rbyte_d == c_read_len) begin
                            // Outputs register here so they are live during PUBLISH.
                            state_d     = S_PUBLISH;
                            frame_stb_d = 1'b1;
                            for (int b = 0; b < c_nblob; b++) begin
                                blob_x_d[b]     = {rbuf_d[3 + 3 * b][5:4], rbuf_d[1 + 3 * b]};
                                blob_y_d[b]     = {rbuf_d[3 + 3 * b][7:6], rbuf_d[2 + 3 * b]};
                                blob_valid_d[b] = !(blob_x_d[b] == 10'h3FF && blob_y_d[b] == 10'h3FF);
                            end
                        end else begin
                            kind_d = K_PTR;
                        end
                    end
                endcase
            end
            S_PUBLISH: begin
                state_d = S_WAIT;
                kind_d  = K_PTR;
                timer_d = POLL_CYCLES;
            end
            default: state_d = S_WAIT;
        endcase

        m_start_d = (state_d == S_ISSUE);
        if (state_q == S_WAIT && state_d == S_ISSUE) begin
            m_rw_d      = (kind_q == K_READ);
            m_packets_d = (kind_q == K_INIT) ? 5'd2 :
                          (kind_q == K_PTR)  ? 5'd1 : 5'd13;
        end
        m_data_d = byte_sel(kind_d, init_k_d, idx_d);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_WAIT;
            kind_q       <= K_INIT;
            init_k_q     <= 3'd0;
            timer_q      <= STARTUP_CYCLES;
            idx_q        <= 4'd0;
            rbyte_q      <= 4'd0;
            m_data_req_q <= 1'b0;
            init_done_q  <= 1'b0;
            frame_stb_q  <= 1'b0;
            m_start_q    <= 1'b0;
            m_rw_q       <= 1'b0;
            m_packets_q  <= 5'd0;
            m_data_q     <= 8'h00;
            for (int i = 1; i <= c_last_byte; i++) rbuf_q[i] <= 8'h00;
            for (int b = 0; b < c_nblob; b++) begin
                blob_x_q[b]     <= 10'h3FF;
                blob_y_q[b]     <= 10'h3FF;
                blob_valid_q[b] <= 1'b0;
            end
        end else begin
            state_q      <= state_d;
            kind_q       <= kind_d;
            init_k_q     <= init_k_d;
            timer_q      <= timer_d;
            idx_q        <= idx_d;
            rbyte_q      <= rbyte_d;
            m_data_req_q <= m_data_req_d;
            init_done_q  <= init_done_d;
            frame_stb_q  <= frame_stb_d;
            m_start_q    <= m_start_d;
            m_rw_q       <= m_rw_d;
            m_packets_q  <= m_packets_d;
            m_data_q     <= m_data_d;
            rbuf_q       <= rbuf_d;
            blob_x_q     <= blob_x_d;
            blob_y_q     <= blob_y_d;
            blob_valid_q <= blob_valid_d;
        end
    end

    assign m_start    = m_start_q;
    assign m_addr     = I2C_ADDR;
    assign m_rw       = m_rw_q;
    assign m_packets  = m_packets_q;
    assign m_data     = m_data_q;
    assign blob_x     = blob_x_q[0];
    assign blob_y     = blob_y_q[0];
    assign blob_valid = blob_valid_q[0];
    assign frame_stb  = frame_stb_q;
    assign init_done  = init_done_q;
`ifdef IR_CAM_ALL_BLOBS_EN
    assign blob1_x     = blob_x_q[1];
    assign blob1_y     = blob_y_q[1];
    assign blob1_valid = blob_valid_q[1];
    assign blob2_x     = blob_x_q[2];
    assign blob2_y     = blob_y_q[2];
    assign blob2_valid = blob_valid_q[2];
    assign blob3_x     = blob_x_q[3];
    assign blob3_y     = blob_y_q[3];
    assign blob3_valid = blob_valid_q[3];
`endif

endmodule
`default_nettype wire

// File: tb/tb_ir_cam_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ir_cam_sequencer
// Brief    : Self-checking bench for ir_cam_sequencer with an i2c_master
//            behavioural model and a byte-level blob reference.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_ir_cam_sequencer;
    localparam logic [23:0] STARTUP = 24'd20;
    localparam logic [23:0] GAP     = 24'd5;
    localparam logic [23:0] POLL    = 24'd30;
`ifdef IR_CAM_ALL_BLOBS_EN
    localparam int NB = 4;
`else
    localparam int NB = 1;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       m_ready = 1'b1;
    logic       m_data_req = 1'b0;
    logic       m_data_ready = 1'b0;
    logic [7:0] m_data_out = 8'h00;
    logic       m_start, m_rw, blob_valid, frame_stb, init_done;
    logic [6:0] m_addr;
    logic [4:0] m_packets;
    logic [7:0] m_data;
    logic [9:0] blob_x, blob_y;
    logic [9:0] dut_bx [4];
    logic [9:0] dut_by [4];
    logic       dut_bv [4];

    ir_cam_sequencer #(
        .I2C_ADDR(7'h58), .STARTUP_CYCLES(STARTUP), .GAP_CYCLES(GAP), .POLL_CYCLES(POLL)
    ) dut (
        .clk(clk), .reset(reset), .m_ready(m_ready), .m_data_req(m_data_req),
        .m_data_ready(m_data_ready), .m_data_out(m_data_out), .m_start(m_start),
        .m_addr(m_addr), .m_rw(m_rw), .m_packets(m_packets), .m_data(m_data),
        .blob_x(blob_x), .blob_y(blob_y), .blob_valid(blob_valid),
`ifdef IR_CAM_ALL_BLOBS_EN
        .blob1_x(dut_bx[1]), .blob1_y(dut_by[1]), .blob1_valid(dut_bv[1]),
        .blob2_x(dut_bx[2]), .blob2_y(dut_by[2]), .blob2_valid(dut_bv[2]),
        .blob3_x(dut_bx[3]), .blob3_y(dut_by[3]), .blob3_valid(dut_bv[3]),
`endif
        .frame_stb(frame_stb), .init_done(init_done)
    );

    assign dut_bx[0] = blob_x;
    assign dut_by[0] = blob_y;
    assign dut_bv[0] = blob_valid;

    always #5 clk = ~clk;

    typedef struct {
        logic       rw;
        logic [4:0] pk;
        logic [7:0] b0;
        logic [7:0] b1;
        int         hold;
        bit         unstable;
        bit         glitch;
    } txn_t;

    txn_t       log_q[$];
    txn_t       cur;
    logic [7:0] rd_bytes [0:12];
    int         rd_len = 13;
    int         delay_cfg = 0;
    int         mst = 0, cnt = 0, nb = 0, step = 0, rk = 0;
    int         frame_cnt = 0;
    int         n_checks = 0, n_pass = 0;
    logic [15:0] init_tbl [0:5] = '{16'h3001, 16'h3008, 16'h0690, 16'h08C0, 16'h1A40, 16'h3303};

    // i2c_master model: accepts m_start after delay_cfg extra cycles, pulls
    // write bytes with m_data_req pulses, returns rd_bytes[0..rd_len-1].
    initial begin
        forever begin
            @(negedge clk);
            m_data_ready = 1'b0;
            if (reset) begin
                mst = 0; m_ready = 1'b1; m_data_req = 1'b0; rk = 0;
            end else begin
                case (mst)
                    0: if (m_start) begin
                        cur.rw = m_rw; cur.pk = m_packets; cur.b0 = m_data; cur.b1 = 8'h00;
                        cur.hold = 1; cur.unstable = 1'b0; cur.glitch = 1'b0;
                        cnt = 0; mst = 1;
                    end
                    1: begin
                        if (m_start) cur.hold++;
                        if (m_data !== cur.b0 || m_rw !== cur.rw || m_packets !== cur.pk)
                            cur.unstable = 1'b1;
                        if (cnt < delay_cfg) cnt++;
                        else begin
                            m_ready = 1'b0; nb = 1; step = 0; rk = 0;
                            mst = cur.rw ? 3 : 2;
                        end
                    end
                    2: begin
                        if (m_start) cur.glitch = 1'b1;
                        if (nb >= int'(cur.pk)) begin
                            m_ready = 1'b1; log_q.push_back(cur); mst = 0;
                        end else begin
                            case (step)
                                0: begin m_data_req = 1'b1; step = 1; end
                                1: begin m_data_req = 1'b0; step = 2; end
                                2: step = 3;
                                default: begin
                                    if (nb == 1) cur.b1 = m_data;
                                    nb++; step = 0;
                                end
                            endcase
                        end
                    end
                    default: begin
                        if (m_start) cur.glitch = 1'b1;
                        if (step == 1) step = 0;
                        else if (rk >= rd_len) begin
                            m_ready = 1'b1; log_q.push_back(cur); mst = 0;
                        end else begin
                            m_data_out = rd_bytes[rk]; m_data_ready = 1'b1; rk++; step = 1;
                        end
                    end
                endcase
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (frame_stb === 1'b1) frame_cnt++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1);
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Reference unpack straight from the byte layout of blob k.
    function automatic void ref_blob(input int k, output int x, output int y, output bit v);
        int b1, b2, b3;
        b1 = int'(rd_bytes[1 + 3 * k]);
        b2 = int'(rd_bytes[2 + 3 * k]);
        b3 = int'(rd_bytes[3 + 3 * k]);
        x = ((b3 / 16) % 4) * 256 + b1;
        y = (b3 / 64) * 256 + b2;
        v = !(x == 1023 && y == 1023);
    endfunction

    task automatic fill_random();
        for (int i = 0; i < 13; i++) rd_bytes[i] = 8'($urandom_range(0, 255));
    endtask

    task automatic run_poll(output bit ok, output int dlog, output bit one_stb);
        int n0, t;
        n0 = log_q.size();
        t = 0;
        while (frame_stb !== 1'b1 && t < 3000) begin tick(); t++; end
        ok = (frame_stb === 1'b1);
        dlog = log_q.size() - n0;
        tick();
        one_stb = (frame_stb === 1'b0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        n_checks++;
        if ({m_start, m_addr, m_rw, m_packets, m_data} !== {1'b0, 7'h58, 1'b0, 5'd0, 8'h00})
            $display("FAIL reset_ctrl: got start=%b addr=%h rw=%b pk=%0d data=%h, expected 0/58/0/0/00",
                     m_start, m_addr, m_rw, m_packets, m_data);
        else n_pass++;
        n_checks++;
        if ({blob_x, blob_y, blob_valid, frame_stb, init_done} !== {10'h3FF, 10'h3FF, 3'b000})
            $display("FAIL reset_blob: got x=%h y=%h v=%b stb=%b done=%b, expected 3ff/3ff/0/0/0",
                     blob_x, blob_y, blob_valid, frame_stb, init_done);
        else n_pass++;
    endtask

    task automatic test_init();
        int n, t;
        bit bad;
        log_q.delete();
        reset = 1'b0;
        n = 0;
        while (m_start !== 1'b1 && n < 500) begin tick(); n++; end
        n_checks++;
        if (n != int'(STARTUP) + 1) $display("FAIL startup_delay: got %0d cycles, expected %0d", n, int'(STARTUP) + 1);
        else n_pass++;
        t = 0;
        while (init_done !== 1'b1 && t < 3000) begin
            tick(); t++;
            if (init_done !== 1'b1 && log_q.size() > 6) break;
        end
        n_checks++;
        if (init_done !== 1'b1 || log_q.size() != 6)
            $display("FAIL init_count: got done=%b writes=%0d, expected 1/6", init_done, log_q.size());
        else n_pass++;
        bad = 1'b0;
        for (int i = 0; i < 6 && i < log_q.size(); i++) begin
            n_checks++;
            if ({log_q[i].rw, log_q[i].pk, log_q[i].b0, log_q[i].b1} !== {1'b0, 5'd2, init_tbl[i]})
                $display("FAIL init_entry%0d: got rw=%b pk=%0d %h/%h, expected 0/2 %h/%h", i,
                         log_q[i].rw, log_q[i].pk, log_q[i].b0, log_q[i].b1, init_tbl[i][15:8], init_tbl[i][7:0]);
            else n_pass++;
            if (log_q[i].unstable || log_q[i].glitch || log_q[i].hold != 2) bad = 1'b1;
        end
        n_checks++;
        if (bad) $display("FAIL init_handshake: got protocol error flag 1, expected 0");
        else n_pass++;
    endtask

    task automatic check_poll_pair(input string nm, input int dlog);
        int n;
        n = log_q.size();
        n_checks++;
        if (dlog != 2 || n < 2 ||
            {log_q[n-2].rw, log_q[n-2].pk, log_q[n-2].b0, log_q[n-1].rw, log_q[n-1].pk} !==
            {1'b0, 5'd1, 8'h36, 1'b1, 5'd13})
            $display("FAIL %s_txns: got %0d new transactions (ptr rw=%b pk=%0d b=%h, rd rw=%b pk=%0d), expected 2 (0/1/36, 1/13)",
                     nm, dlog, log_q[n-2].rw, log_q[n-2].pk, log_q[n-2].b0, log_q[n-1].rw, log_q[n-1].pk);
        else n_pass++;
    endtask

    task automatic test_poll();
        bit ok, one;
        int dlog;
        for (int i = 0; i < 13; i++) rd_bytes[i] = 8'hFF;
        rd_bytes[0] = 8'h00; rd_bytes[1] = 8'h64; rd_bytes[2] = 8'hC8; rd_bytes[3] = 8'h50;
        run_poll(ok, dlog, one);
        n_checks++;
        if (!ok || {blob_x, blob_y, blob_valid} !== {10'h164, 10'h1C8, 1'b1})
            $display("FAIL poll_blob: got frame=%b x=%h y=%h v=%b, expected 1 164/1c8/1", ok, blob_x, blob_y, blob_valid);
        else n_pass++;
        n_checks++;
        if (!one) $display("FAIL poll_stb_width: got frame_stb high 2+ cycles, expected 1");
        else n_pass++;
        check_poll_pair("poll", dlog);
    endtask

    task automatic test_invalid_blob();
        bit ok, one;
        int dlog;
        fill_random();
        rd_bytes[1] = 8'hFF; rd_bytes[2] = 8'hFF; rd_bytes[3] = 8'hFF;
        run_poll(ok, dlog, one);
        n_checks++;
        if (!ok || !one || {blob_x, blob_y, blob_valid} !== {10'h3FF, 10'h3FF, 1'b0})
            $display("FAIL invalid_blob: got frame=%b single=%b x=%h y=%h v=%b, expected 1 1 3ff/3ff/0",
                     ok, one, blob_x, blob_y, blob_valid);
        else n_pass++;
    endtask

    task automatic test_random_polls();
        bit ok, one;
        int dlog, x, y, n;
        bit v;
        for (int it = 0; it < 8; it++) begin
            fill_random();
            if ($urandom_range(0, 3) == 0) begin
                rd_bytes[1] = 8'hFF; rd_bytes[2] = 8'hFF; rd_bytes[3] = 8'hFF;
            end
            delay_cfg = $urandom_range(0, 3);
            run_poll(ok, dlog, one);
            n = log_q.size();
            for (int k = 0; k < NB; k++) begin
                ref_blob(k, x, y, v);
                n_checks++;
                if (!ok || {dut_bx[k], dut_by[k], dut_bv[k]} !== {10'(x), 10'(y), v})
                    $display("FAIL rand%0d_blob%0d: got frame=%b x=%h y=%h v=%b, expected x=%h y=%h v=%b",
                             it, k, ok, dut_bx[k], dut_by[k], dut_bv[k], 10'(x), 10'(y), v);
                else n_pass++;
            end
            n_checks++;
            if (!one || dlog != 2 || log_q[n-1].hold != delay_cfg + 2 || log_q[n-1].unstable)
                $display("FAIL rand%0d_handshake: got single=%b new=%0d hold=%0d, expected 1 2 %0d",
                         it, one, dlog, log_q[n-1].hold, delay_cfg + 2);
            else n_pass++;
        end
        delay_cfg = 0;
    endtask

    task automatic test_short_read();
        bit ok, one;
        int dlog, n0, f0, t, x, y;
        bit v;
        logic [9:0] x0;
        x0 = blob_x;
        f0 = frame_cnt;
        n0 = log_q.size();
        fill_random();
        rd_len = 5;
        t = 0;
        while (log_q.size() < n0 + 2 && t < 3000) begin tick(); t++; end
        repeat (10) tick();
        n_checks++;
        if (log_q.size() < n0 + 2 || frame_cnt != f0 || blob_x !== x0)
            $display("FAIL short_read_hold: got txns=%0d frames=%0d x=%h, expected %0d %0d %h",
                     log_q.size() - n0, frame_cnt - f0, blob_x, 2, 0, x0);
        else n_pass++;
        rd_len = 13;
        run_poll(ok, dlog, one);
        ref_blob(0, x, y, v);
        n_checks++;
        if (!ok || {blob_x, blob_y, blob_valid} !== {10'(x), 10'(y), v})
            $display("FAIL short_read_retry: got frame=%b x=%h y=%h, expected 1 %h %h", ok, blob_x, blob_y, 10'(x), 10'(y));
        else n_pass++;
    endtask

    task automatic test_slow_ready();
        bit ok, one;
        int dlog, n;
        fill_random();
        delay_cfg = 18;
        run_poll(ok, dlog, one);
        n = log_q.size();
        n_checks++;
        if (!ok || n < 2 || log_q[n-1].hold != 20 || log_q[n-2].hold != 20)
            $display("FAIL slow_hold: got frame=%b hold ptr=%0d rd=%0d, expected 20/20", ok, log_q[n-2].hold, log_q[n-1].hold);
        else n_pass++;
        n_checks++;
        if (dlog != 2 || log_q[n-1].unstable || log_q[n-2].unstable || log_q[n-1].glitch || log_q[n-2].glitch)
            $display("FAIL slow_stable: got new=%0d unstable/dup flags set, expected 2 and clean", dlog);
        else n_pass++;
        delay_cfg = 0;
    endtask

    task automatic test_reset_mid_read();
        int t, n;
        fill_random();
        t = 0;
        while (!(mst == 3 && rk >= 7) && t < 3000) begin tick(); t++; end
        n_checks++;
        if (!(mst == 3 && rk >= 7)) $display("FAIL midread_reach: got rk=%0d, expected >=7", rk);
        else n_pass++;
        reset = 1'b1;
        repeat (2) tick();
        n_checks++;
        if ({m_start, m_addr, m_rw, m_packets, m_data, blob_x, blob_y, blob_valid, frame_stb, init_done} !==
            {1'b0, 7'h58, 1'b0, 5'd0, 8'h00, 10'h3FF, 10'h3FF, 3'b000})
            $display("FAIL midread_reset: got start=%b rw=%b pk=%0d data=%h x=%h y=%h v=%b done=%b, expected reset values",
                     m_start, m_rw, m_packets, m_data, blob_x, blob_y, blob_valid, init_done);
        else n_pass++;
        log_q.delete();
        reset = 1'b0;
        n = 0;
        while (m_start !== 1'b1 && n < 500) begin tick(); n++; end
        n_checks++;
        if (n != int'(STARTUP) + 1) $display("FAIL midread_startup: got %0d cycles, expected %0d", n, int'(STARTUP) + 1);
        else n_pass++;
        t = 0;
        while (log_q.size() < 1 && t < 500) begin tick(); t++; end
        n_checks++;
        if (log_q.size() < 1 || {log_q[0].rw, log_q[0].pk, log_q[0].b0, log_q[0].b1} !== {1'b0, 5'd2, 16'h3001})
            $display("FAIL midread_restart: got txns=%0d first=%h/%h, expected 30/01", log_q.size(), log_q[0].b0, log_q[0].b1);
        else n_pass++;
    endtask

`ifdef IR_CAM_ALL_BLOBS_EN
    task automatic test_all_blobs();
        bit ok, one;
        int dlog, t;
        t = 0;
        while (init_done !== 1'b1 && t < 3000) begin tick(); t++; end
        fill_random();
        rd_bytes[10] = 8'h22; rd_bytes[11] = 8'h33; rd_bytes[12] = 8'hA0;
        run_poll(ok, dlog, one);
        n_checks++;
        if (!ok || {dut_bx[3], dut_by[3], dut_bv[3]} !== {10'h222, 10'h233, 1'b1})
            $display("FAIL blob3: got frame=%b x=%h y=%h v=%b, expected 222/233/1", ok, dut_bx[3], dut_by[3], dut_bv[3]);
        else n_pass++;
    endtask
`endif

    initial begin
        for (int i = 0; i < 13; i++) rd_bytes[i] = 8'h00;
        test_reset();
        test_init();
        test_poll();
        test_invalid_blob();
        test_random_polls();
        test_short_read();
        test_slow_ready();
        test_reset_mid_read();
`ifdef IR_CAM_ALL_BLOBS_EN
        test_all_blobs();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
